// File: rtl/div_const_pkg.sv
// Shared widths and the divisor constant for the divide-by-3 stream.
package div_const_pkg;
  localparam int DIV_W = 32;
  localparam int Q_W   = 31;
  localparam int R_W   = 2;
  localparam int CNT_W = 16;
  localparam logic [DIV_W-1:0] DIVISOR = 32'd3;
endpackage

// File: rtl/div_32_3.sv
// Combinational 32-bit divide by the constant 3 via a restoring long division.
module div_32_3
  import div_const_pkg::*;
(
  input  logic [DIV_W-1:0] x,
  output logic [Q_W-1:0]   q
);

  localparam logic [2:0] D3 = 3'(DIVISOR);

  logic [1:0] rem;
  logic [2:0] t;

  // The MSB alone never reaches 3, so it seeds the partial remainder
  // and the quotient is only 31 bits wide.
  always_comb begin
    q   = '0;
    t   = '0;
    rem = {1'b0, x[DIV_W-1]};
    for (int i = Q_W - 1; i >= 0; i--) begin
      t = {rem, x[i]};
      if (t >= D3) begin
        q[i] = 1'b1;
        rem  = 2'(t - D3);
      end else begin
        rem  = t[1:0];
      end
    end
  end

endmodule

// File: rtl/div_32_3_stream.sv
// Two-stage valid/ready pipeline producing floor(x/3) and x mod 3,
// with an optional remainder self-check and a delivered-result counter.
module div_32_3_stream
  import div_const_pkg::*;
#(
  parameter bit CHECK_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DIV_W-1:0] in_x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Q_W-1:0]   out_q,
  output logic [R_W-1:0]   out_r,
  output logic             err,
  output logic [CNT_W-1:0] res_cnt
);

  logic [DIV_W-1:0] x1;
  logic             v1;
  logic [Q_W-1:0]   q2;
  logic [R_W-1:0]   r2;
  logic             v2;

  logic [Q_W-1:0]   q_calc;
  logic [DIV_W-1:0] d_calc;
  logic             s1_load;
  logic             s2_load;
  logic             out_xfer;

  div_32_3 u_div (
    .x (x1),
    .q (q_calc)
  );

  assign d_calc = x1 - DIVISOR * {1'b0, q_calc};

  assign in_ready = !v1 || !v2 || out_ready;
  assign s1_load  = in_valid && in_ready;
  assign s2_load  = v1 && (!v2 || out_ready);
  assign out_xfer = v2 && out_ready;

  assign out_valid = v2;
  assign out_q     = q2;
  assign out_r     = r2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x1 <= '0;
      v1 <= 1'b0;
    end else if (s1_load) begin
      x1 <= in_x;
      v1 <= 1'b1;
    end else if (s2_load) begin
      v1 <= 1'b0;
    end
  end

  // S2 either takes the S1 result or drains when its result is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q2 <= '0;
      r2 <= '0;
      v2 <= 1'b0;
    end else if (s2_load) begin
      q2 <= q_calc;
      r2 <= d_calc[R_W-1:0];
      v2 <= 1'b1;
    end else if (out_xfer) begin
      v2 <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_cnt <= '0;
    end else if (out_xfer) begin
      res_cnt <= res_cnt + 1'b1;
    end
  end

  generate
    if (CHECK_EN) begin : g_check
      logic chk_bad;
      assign chk_bad = (d_calc[DIV_W-1:R_W] != '0) || (d_calc[R_W-1:0] == 2'd3);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          err <= 1'b0;
        end else if (s2_load && chk_bad) begin
          err <= 1'b1;
        end
      end
    end else begin : g_no_check
      assign err = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_div_32_3_stream.sv
// Directed and streaming checks for div_32_3_stream.
module tb_div_32_3_stream;
  import div_const_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DIV_W-1:0] in_x = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [Q_W-1:0]   out_q;
  logic [R_W-1:0]   out_r;
  logic             err;
  logic [CNT_W-1:0] res_cnt;

  int errors = 0;
  int checks = 0;

  div_32_3_stream #(.CHECK_EN(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_r     (out_r),
    .err       (err),
    .res_cnt   (res_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [30:0] q;
    logic [1:0]  r;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] sb[$];
    logic [31:0] ex;
    int sent;
    int delivered;
    int cyc;

    vecs[0] = '{32'd0,          31'd0,          2'd0};
    vecs[1] = '{32'd1,          31'd0,          2'd1};
    vecs[2] = '{32'd2,          31'd0,          2'd2};
    vecs[3] = '{32'd3,          31'd1,          2'd0};
    vecs[4] = '{32'hFFFF_FFFF,  31'h5555_5555,  2'd0};
    vecs[5] = '{32'd100,        31'd33,         2'd1};
    vecs[6] = '{32'd1000001,    31'd333333,     2'd2};

    // reset state
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_res_cnt", 64'(res_cnt), 64'd0);
    chk("rst_out_q", 64'(out_q), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // single item latency
    in_valid = 1'b1; in_x = 32'd100; out_ready = 1'b1;
    #1 chk("single_in_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    #1 chk("single_not_yet", 64'(out_valid), 64'd0);
    step();
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_q", 64'(out_q), 64'd33);
    chk("single_r", 64'(out_r), 64'd1);
    step();
    chk("single_drained", 64'(out_valid), 64'd0);
    chk("single_cnt", 64'(res_cnt), 64'd1);

    // back-to-back stream from the vector table
    for (int i = 0; i <= 7; i++) begin
      if (i < 7) begin
        in_valid = 1'b1;
        in_x = vecs[i].x;
        #1 chk("stream_in_ready", 64'(in_ready), 64'd1);
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (i >= 1) begin
        chk("stream_valid", 64'(out_valid), 64'd1);
        chk("stream_q", 64'(out_q), 64'(vecs[i-1].q));
        chk("stream_r", 64'(out_r), 64'(vecs[i-1].r));
      end
    end
    step();
    chk("stream_drained", 64'(out_valid), 64'd0);
    chk("stream_cnt", 64'(res_cnt), 64'd8);

    // backpressure: five cycles of out_ready low while feeding 7, 8, 9
    out_ready = 1'b0;
    in_valid = 1'b1; in_x = 32'd7;
    step();
    in_x = 32'd8;
    step();
    in_x = 32'd9;
    #1;
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    chk("bp_valid", 64'(out_valid), 64'd1);
    chk("bp_q", 64'(out_q), 64'd2);
    chk("bp_r", 64'(out_r), 64'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_hold_ready", 64'(in_ready), 64'd0);
      chk("bp_hold_q", 64'(out_q), 64'd2);
      chk("bp_hold_r", 64'(out_r), 64'd1);
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk("bp_second_q", 64'(out_q), 64'd2);
    chk("bp_second_r", 64'(out_r), 64'd2);
    step();
    chk("bp_third_q", 64'(out_q), 64'd3);
    chk("bp_third_r", 64'(out_r), 64'd0);
    chk("bp_third_valid", 64'(out_valid), 64'd1);
    step();
    chk("bp_drained", 64'(out_valid), 64'd0);
    chk("bp_cnt", 64'(res_cnt), 64'd11);

    // reset with both stages full
    out_ready = 1'b0;
    in_valid = 1'b1; in_x = 32'd5;
    step();
    in_x = 32'd6;
    step();
    in_valid = 1'b0;
    #1;
    chk("mid_pre_valid", 64'(out_valid), 64'd1);
    chk("mid_pre_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_cnt", 64'(res_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("mid_no_stale", 64'(out_valid), 64'd0);
    end

    // 65536 transfers: counter wrap plus per-result arithmetic
    sent = 0; delivered = 0; cyc = 0;
    while (delivered < 65536 && cyc < 90000) begin
      out_ready = (cyc < 1024) ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_valid  = (sent < 65536) && ((cyc < 1024) ? ($urandom_range(0, 3) != 0) : 1'b1);
      in_x      = $urandom;
      #1;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("wrap_unexpected_result", 64'd1, 64'd0);
        end else begin
          ex = sb.pop_front();
          chk("wrap_q", 64'(out_q), 64'(ex / 32'd3));
          chk("wrap_r", 64'(out_r), 64'(ex % 32'd3));
        end
        delivered++;
      end
      if (in_valid && in_ready) begin
        sb.push_back(in_x);
        sent++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    chk("wrap_delivered", 64'(delivered), 64'd65536);
    chk("wrap_cnt", 64'(res_cnt), 64'd0);
    chk("wrap_err", 64'(err), 64'd0);

    // corrupt the divider output; err must latch and stay set
    force dut.q_calc = 31'd0;
    in_valid = 1'b1; in_x = 32'd100; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("force_err_set", 64'(err), 64'd1);
    release dut.q_calc;
    in_valid = 1'b1; in_x = 32'd9;
    step();
    in_valid = 1'b0;
    step();
    chk("force_good_q", 64'(out_q), 64'd3);
    step();
    chk("force_err_sticky", 64'(err), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
